// File: rtl/seq_chunk_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_chunk_alu
//  Purpose  : Multi-cycle add/subtract ALU. It ripples one CHUNK-bit slice per
//             clock and registers the sign/carry/zero/parity/overflow flags.
//  Revision : 1.0
// ============================================================================
module seq_chunk_alu #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             sign,
    output logic             carry,
    output logic             zero,
    output logic             parity,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_c;
    logic [WIDTH-1:0]  r_res;
    logic [WIDTH-1:0]  r_out;
    logic              r_sign;
    logic              r_carry;
    logic              r_zero;
    logic              r_parity;
    logic              r_overflow;

    logic              w_accept;
    logic              w_last;
    logic [CHUNK:0]    w_slice;
    logic [WIDTH-1:0]  w_res_next;

    // A new operation is only taken when no operation is in flight.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_idx == c_last_idx);

    assign w_slice = {1'b0, r_a[r_idx*CHUNK +: CHUNK]}
                   + {1'b0, r_b[r_idx*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, r_c};

    always_comb begin
        w_res_next = r_res;
        w_res_next[r_idx*CHUNK +: CHUNK] = w_slice[CHUNK-1:0];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_RUN;
            S_RUN:   if (w_last)   w_state_next = S_DONE;
            S_DONE:  w_state_next = w_accept ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= 1'b0;
            r_res      <= '0;
            r_out      <= '0;
            r_sign     <= 1'b0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_parity   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                // Subtraction is A + ~B + 1, the +1 entering as the initial carry.
                r_a   <= X;
                r_b   <= op ? ~Y : Y;
                r_c   <= op;
                r_idx <= '0;
            end else if (r_state == S_RUN) begin
                r_res <= w_res_next;
                r_c   <= w_slice[CHUNK];
                r_idx <= w_last ? '0 : r_idx + 1'b1;
                if (w_last) begin
                    r_out      <= w_res_next;
                    r_sign     <= w_res_next[WIDTH-1];
                    r_carry    <= w_slice[CHUNK];
                    r_zero     <= (w_res_next == '0);
                    r_parity   <= ~^w_res_next;
                    r_overflow <= (r_a[WIDTH-1] & r_b[WIDTH-1] & ~w_res_next[WIDTH-1])
                                | (~r_a[WIDTH-1] & ~r_b[WIDTH-1] & w_res_next[WIDTH-1]);
                end
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign out      = r_out;
    assign sign     = r_sign;
    assign carry    = r_carry;
    assign zero     = r_zero;
    assign parity   = r_parity;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_chunk_alu
//  Purpose  : Directed vector bench for seq_chunk_alu in three geometries
//             (16/4, 32/8, 16/16).
//  Revision : 1.0
// ============================================================================
module tb_seq_chunk_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  st, opv, dn, bz, sg, cy, zr, pa, ov;
    logic [15:0] xa, ya, oa, xc, yc, oc;
    logic [31:0] xb, yb, ob;

    seq_chunk_alu #(.WIDTH(16), .CHUNK(4)) u_a (
        .clk(clk), .rst(rst), .start(st[0]), .op(opv[0]), .X(xa), .Y(ya),
        .busy(bz[0]), .done(dn[0]), .out(oa), .sign(sg[0]), .carry(cy[0]),
        .zero(zr[0]), .parity(pa[0]), .overflow(ov[0]));

    seq_chunk_alu #(.WIDTH(32), .CHUNK(8)) u_b (
        .clk(clk), .rst(rst), .start(st[1]), .op(opv[1]), .X(xb), .Y(yb),
        .busy(bz[1]), .done(dn[1]), .out(ob), .sign(sg[1]), .carry(cy[1]),
        .zero(zr[1]), .parity(pa[1]), .overflow(ov[1]));

    seq_chunk_alu #(.WIDTH(16), .CHUNK(16)) u_c (
        .clk(clk), .rst(rst), .start(st[2]), .op(opv[2]), .X(xc), .Y(yc),
        .busy(bz[2]), .done(dn[2]), .out(oc), .sign(sg[2]), .carry(cy[2]),
        .zero(zr[2]), .parity(pa[2]), .overflow(ov[2]));

    typedef struct {
        int          sel;
        logic        op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] eo;
        logic [4:0]  ef;   // {sign, carry, zero, parity, overflow}
        int          lat;
    } vec_t;

    vec_t vt[8];
    int   total = 0;
    int   bad   = 0;
    int   lat, nb;
    bit   ok, seen;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] get_out(input int s);
        case (s)
            0:       return {16'h0, oa};
            1:       return ob;
            default: return {16'h0, oc};
        endcase
    endfunction

    function automatic logic [4:0] get_fl(input int s);
        return {sg[s], cy[s], zr[s], pa[s], ov[s]};
    endfunction

    task automatic drive(input int s, input logic o, input logic [31:0] x,
                         input logic [31:0] y, input logic go);
        case (s)
            0:       begin xa = x[15:0]; ya = y[15:0]; end
            1:       begin xb = x;       yb = y;       end
            default: begin xc = x[15:0]; yc = y[15:0]; end
        endcase
        opv[s] = o;
        st[s]  = go;
    endtask

    // Counts edges until done is seen; each loop pass sits at a falling edge.
    task automatic wait_done(input int s, output int l, output int nbusy, output bit fin);
        l = 0; nbusy = 0; fin = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (dn[s]) begin
                fin = 1'b1;
                break;
            end
            if (bz[s]) nbusy++;
            @(negedge clk);
            l++;
        end
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL timeout: dut=%0d done=0 after %0d cycles, want done=1", s, l);
        end
    endtask

    task automatic run_op(input int s, input logic o, input logic [31:0] x,
                          input logic [31:0] y, output int l, output int nbusy);
        bit fin;
        drive(s, o, x, y, 1'b1);
        @(negedge clk);
        st[s] = 1'b0;
        wait_done(s, l, nbusy, fin);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{0, 1'b0, 32'h7FFF,     32'h0001,     32'h8000, 5'b10001, 4};
        vt[1] = '{0, 1'b0, 32'hFFFF,     32'h0001,     32'h0000, 5'b01110, 4};
        vt[2] = '{0, 1'b1, 32'h0000,     32'h0001,     32'hFFFF, 5'b10010, 4};
        vt[3] = '{0, 1'b1, 32'h8000,     32'h0001,     32'h7FFF, 5'b01001, 4};
        vt[4] = '{1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0,    5'b01110, 4};
        vt[5] = '{1, 1'b1, 32'h5,        32'h5,        32'h0,    5'b01110, 4};
        vt[6] = '{2, 1'b0, 32'h7FFF,     32'h0001,     32'h8000, 5'b10001, 1};
        vt[7] = '{2, 1'b1, 32'h0000,     32'h0001,     32'hFFFF, 5'b10010, 1};

        rst = 1'b1; st = '0; opv = '0;
        xa = '0; ya = '0; xb = '0; yb = '0; xc = '0; yc = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset_out%0d", s), get_out(s), 32'h0);
            check($sformatf("reset_flags%0d", s), {27'h0, get_fl(s)}, 32'h0);
            check($sformatf("reset_busydone%0d", s), {30'h0, bz[s], dn[s]}, 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].sel, vt[i].op, vt[i].x, vt[i].y, lat, nb);
            check($sformatf("vec%0d_out", i), get_out(vt[i].sel), vt[i].eo);
            check($sformatf("vec%0d_flags", i), {27'h0, get_fl(vt[i].sel)}, {27'h0, vt[i].ef});
            check($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            check($sformatf("vec%0d_busy_cycles", i), nb, vt[i].lat);
            @(negedge clk);
        end

        // Start during RUN and operand changes must be ignored; restart in DONE.
        drive(0, 1'b0, 32'h1234, 32'h1111, 1'b1);
        @(negedge clk);
        drive(0, 1'b1, 32'hFFFF, 32'hFFFF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        drive(0, 1'b1, 32'hAAAA, 32'h5555, 1'b0);
        wait_done(0, lat, nb, ok);
        check("ignore_latency", lat, 2);
        check("ignore_out", get_out(0), 32'h2345);
        check("ignore_flags", {27'h0, get_fl(0)}, 32'h02);
        drive(0, 1'b0, 32'h0001, 32'h0001, 1'b1);
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0, lat, nb, ok);
        check("b2b_gap", lat + 1, 5);
        check("b2b_out", get_out(0), 32'h0002);
        check("b2b_flags", {27'h0, get_fl(0)}, 32'h0);
        @(negedge clk);

        // Reset in the second RUN cycle aborts the operation.
        run_op(0, 1'b0, 32'h7FFF, 32'h0001, lat, nb);
        check("pre_rst_out", get_out(0), 32'h8000);
        @(negedge clk);
        drive(0, 1'b0, 32'hFFFF, 32'hFFFF, 1'b1);
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'h0, bz[0]}, 32'h0);
        check("abort_done", {31'h0, dn[0]}, 32'h0);
        check("abort_out", get_out(0), 32'h0);
        check("abort_flags", {27'h0, get_fl(0)}, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            seen = seen | dn[0];
            @(negedge clk);
        end
        check("abort_no_done", {31'h0, seen}, 32'h0);
        run_op(0, 1'b0, 32'h0003, 32'h0004, lat, nb);
        check("post_rst_out", get_out(0), 32'h0007);
        check("post_rst_latency", lat, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_chunk_alu.md
Name: seq_chunk_alu

Overview:
Multi-cycle, parametrised add/subtract ALU with the same flag set as the team's 16-bit combinational adder-ALU (sign, carry, zero, parity, overflow). It processes one CHUNK-bit ripple-carry slice per clock, so wide operands need no long combinational carry chain. A start/busy/done handshake controls it. It sits as a datapath unit beside the combinational ALU for wide or timing-critical paths.

Parameters:
WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits added per cycle (width of the internal ripple-carry slice).
NCHUNK, WIDTH/CHUNK, derived (localparam); the number of compute cycles.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
op  input  1  0 = X+Y, 1 = X-Y (two's complement); sampled with start.
X  input  WIDTH  operand A; sampled with start.
Y  input  WIDTH  operand B; sampled with start.
busy  output  1  high while an operation is in progress (RUN state).
done  output  1  single-cycle pulse; result and flags are valid from this cycle.
out  output  WIDTH  result; holds until the next completion.
sign  output  1  out[WIDTH-1].
carry  output  1  carry out of the MSB of the effective addition.
zero  output  1  1 when out == 0.
parity  output  1  even parity: XNOR-reduce of out (1 when out has an even count of ones).
overflow  output  1  signed overflow of the effective addition.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, chunk index=0. busy, done, out and all flags = 0. Reset during RUN aborts the operation; no done pulse follows and outputs clear to 0.
- States are IDLE, RUN and DONE.
- IDLE, start=1 at an edge:
  - Latch A=X and B = op ? ~Y : Y.
  - Carry register = op.
  - Index = 0.
  - Go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - Slice i = index computes {c, sum} = A[i*CHUNK +: CHUNK] + B[i*CHUNK +: CHUNK] + carry_reg.
  - sum is written into the result register slice; c goes to carry_reg.
  - Index increments.
  - On the edge processing slice NCHUNK-1, go to DONE and register the flags.
- Flag definitions:
  - carry = final slice carry out. For subtract, carry=1 means no borrow.
  - overflow = (A[MSB] & B[MSB] & ~out[MSB]) | (~A[MSB] & ~B[MSB] & out[MSB]), where B is the already-inverted operand.
  - sign, zero and parity are computed from the final result.
  - All flags are registered, never combinational from live inputs.
- Latency: done=1 in the cycle following the NCHUNK-th edge after the edge that sampled start. busy=1 exactly in the NCHUNK cycles before that.
- DONE: lasts one cycle with done=1 and busy=0, then moves to IDLE. If start=1 in DONE, a new operation is accepted and the next state is RUN (back-to-back, no idle bubble).
- start while busy=1 is ignored. X, Y and op may change freely during RUN without affecting the result.
- out and the flags keep their last completed values through IDLE and RUN. They update only on the edge entering DONE.
- Carry propagates across slices with full wrap: the result is modulo 2^WIDTH, and the carry out of the top slice appears only on the carry flag.

Test Plan:
1. WIDTH=16, CHUNK=4, add 0x7FFF+0x0001 -> done 4 edges after start; out=0x8000, sign=1, overflow=1, carry=0, zero=0, parity=0; busy high exactly 4 cycles.
2. Add 0xFFFF+0x0001 -> out=0x0000, carry=1, zero=1, parity=1, overflow=0, sign=0.
3. Sub 0x0000-0x0001 -> out=0xFFFF, carry=0, sign=1, parity=1, overflow=0. Sub 0x8000-0x0001 -> out=0x7FFF, overflow=1, carry=1, parity=0.
4. Start 0x1234+0x1111; during RUN pulse start with other operands and change X/Y -> ignored; out=0x2345. Then start asserted in the DONE cycle with 0x0001+0x0001 -> second done exactly 5 cycles after the first, out=0x0002.
5. Start an operation; assert rst on the 2nd RUN cycle -> no done pulse; busy=0 and out/flags=0 after the reset edge; a following start completes normally.
6. WIDTH=32, CHUNK=8: 0xFFFFFFFF+0x00000001 -> latency 4 edges, out=0, carry=1, zero=1. WIDTH=16, CHUNK=16 -> latency 1 edge, results match scenario 1.
